// File: rtl/des_pkg.sv
// Shared widths, sequencer state encoding and the eight DES S-box tables.
// Each table row holds 16 nibbles, column 0 in the most significant nibble.
package des_pkg;

  localparam int NUM_SBOX   = 8;
  localparam int SBOX_IN_W  = 6;
  localparam int SBOX_OUT_W = 4;
  localparam int EXP_W      = 48;
  localparam int F_W        = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Indexed by {sbox[2:0], row[1:0]}; S1 occupies entries 0..3.
  localparam logic [63:0] SBOX_ROW [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

endpackage

// File: rtl/des_sbox_bank.sv
// One shared lookup unit: selects one of the eight S-boxes and reads it
// with the raw 6-bit chunk (row = bits 5 and 0, column = bits 4:1).
module des_sbox_bank
  import des_pkg::*;
(
  input  logic [2:0]            sel,
  input  logic [SBOX_IN_W-1:0]  addr,
  output logic [SBOX_OUT_W-1:0] nib
);

  logic [1:0]            row;
  logic [3:0]            col;
  logic [63:0]           row_bits;
  logic [SBOX_OUT_W-1:0] row_nibs [16];

  assign row      = {addr[5], addr[0]};
  assign col      = addr[4:1];
  assign row_bits = SBOX_ROW[{sel, row}];

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      row_nibs[i] = row_bits[SBOX_OUT_W*i +: SBOX_OUT_W];
    end
    nib = row_nibs[4'd15 - col];
  end

endmodule

// File: rtl/des_sbox_sequencer.sv
// Time-multiplexed DES S-box stage: eight 6-bit chunks pass through LANES
// shared lookup units over 8/LANES cycles, with valid/ready on both sides.
module des_sbox_sequencer
  import des_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [EXP_W-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [F_W-1:0]   o_data
);

  localparam int STEPS  = NUM_SBOX / LANES;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  state_t                 state;
  logic [STEP_W-1:0]      step;
  logic [EXP_W-1:0]       cap_q;
  logic [F_W-1:0]         res_nx;
  logic [SBOX_IN_W-1:0]   chunk     [NUM_SBOX];
  logic [2:0]             lane_sel  [LANES];
  logic [SBOX_IN_W-1:0]   lane_addr [LANES];
  logic [SBOX_OUT_W-1:0]  lane_nib  [LANES];

  always_comb begin
    for (int c = 0; c < NUM_SBOX; c++) begin
      chunk[c] = cap_q[EXP_W-1-SBOX_IN_W*c -: SBOX_IN_W];
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign lane_sel[j]  = 3'(int'(step) * LANES + j);
    assign lane_addr[j] = chunk[lane_sel[j]];

    des_sbox_bank u_bank (
      .sel  (lane_sel[j]),
      .addr (lane_addr[j]),
      .nib  (lane_nib[j])
    );
  end

  // Result register with this step's nibbles merged in; only committed in RUN.
  always_comb begin
    res_nx = o_data;
    for (int c = 0; c < NUM_SBOX; c++) begin
      for (int j = 0; j < LANES; j++) begin
        if (lane_sel[j] == 3'(c)) begin
          res_nx[F_W-1-SBOX_OUT_W*c -: SBOX_OUT_W] = lane_nib[j];
        end
      end
    end
  end

  assign o_ready = !i_flush && ((state == IDLE) || ((state == DONE) && i_ready));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      step    <= '0;
      cap_q   <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else if (i_flush) begin
      state   <= IDLE;
      step    <= '0;
      o_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid && o_ready) begin
            cap_q <= i_data;
            step  <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          o_data <= res_nx;
          if (step == LAST_STEP) begin
            step    <= '0;
            o_valid <= 1'b1;
            state   <= DONE;
          end else begin
            step <= step + STEP_W'(1);
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            if (i_valid) begin
              cap_q <= i_data;
              step  <= '0;
              state <= RUN;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          step    <= '0;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_des_sbox_sequencer.sv
// Checks the sequencer at LANES = 1, 4 and 8 against a table-driven model
// of the DES S-box layer, plus backpressure, flush and async reset cases.
module tb_des_sbox_sequencer;

  localparam int NDUT = 3;
  localparam int LN [NDUT] = '{1, 4, 8};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush  [NDUT];
  logic        vld_in [NDUT];
  logic        rdy_out[NDUT];
  logic [47:0] din    [NDUT];
  logic        vld_out[NDUT];
  logic        rdy_in [NDUT];
  logic [31:0] dout   [NDUT];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    des_sbox_sequencer #(.LANES(LN[g])) u_dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_flush (flush[g]),
      .i_valid (vld_in[g]),
      .o_ready (rdy_out[g]),
      .i_data  (din[g]),
      .o_valid (vld_out[g]),
      .i_ready (rdy_in[g]),
      .o_data  (dout[g])
    );
  end

  // Standard DES S-boxes, row-major (row 0..3, column 0..15).
  int sb [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  function automatic logic [31:0] ref_f(input logic [47:0] d);
    logic [31:0] r;
    int ch, row, col;
    r = '0;
    for (int c = 0; c < 8; c++) begin
      ch  = int'((d >> (42 - 6*c)) & 48'h3F);
      row = (ch / 32) * 2 + (ch % 2);
      col = (ch / 2) % 16;
      r   = (r << 4) | 32'(sb[c][row*16 + col]);
    end
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_valid(input int k, output int n);
    n = 0;
    while (!vld_out[k] && n < 40) begin
      check_eq("run_rdy", 64'(rdy_out[k]), 0);
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_word(input int k, input logic [47:0] data, input int stall);
    logic [31:0] exp;
    int n;
    exp = ref_f(data);
    @(negedge clk);
    check_eq("accept_rdy", 64'(rdy_out[k]), 1);
    din[k] = data; vld_in[k] = 1'b1; rdy_in[k] = (stall == 0);
    @(posedge clk); #1;
    vld_in[k] = 1'b0;
    din[k] = 48'({$urandom, $urandom});
    wait_valid(k, n);
    check_eq("latency", 64'(n), 64'(8 / LN[k]));
    check_eq("result", 64'(dout[k]), 64'(exp));
    for (int i = 0; i < stall; i++) begin
      vld_in[k] = 1'($urandom);
      din[k] = 48'({$urandom, $urandom});
      @(posedge clk); #1;
      check_eq("stall_vld", 64'(vld_out[k]), 1);
      check_eq("stall_data", 64'(dout[k]), 64'(exp));
      check_eq("stall_rdy", 64'(rdy_out[k]), 0);
    end
    vld_in[k] = 1'b0; rdy_in[k] = 1'b1;
    #1;
    check_eq("done_rdy", 64'(rdy_out[k]), 1);
    @(posedge clk); #1;
    check_eq("vld_drop", 64'(vld_out[k]), 0);
    check_eq("hold_data", 64'(dout[k]), 64'(exp));
    check_eq("idle_rdy", 64'(rdy_out[k]), 1);
  endtask

  task automatic back_to_back(input int k);
    int n;
    @(negedge clk);
    din[k] = '0; vld_in[k] = 1'b1; rdy_in[k] = 1'b0;
    @(posedge clk); #1;
    vld_in[k] = 1'b0;
    wait_valid(k, n);
    check_eq("b2b_lat1", 64'(n), 64'(8 / LN[k]));
    repeat (5) begin
      din[k] = 48'({$urandom, $urandom}); vld_in[k] = 1'b1;
      @(posedge clk); #1;
      check_eq("bp_vld", 64'(vld_out[k]), 1);
      check_eq("bp_data", 64'(dout[k]), 64'h00000000EFA72C4D);
      check_eq("bp_rdy", 64'(rdy_out[k]), 0);
    end
    din[k] = '1; vld_in[k] = 1'b1; rdy_in[k] = 1'b1;
    #1;
    check_eq("b2b_rdy", 64'(rdy_out[k]), 1);
    @(posedge clk); #1;
    vld_in[k] = 1'b0;
    check_eq("b2b_drop", 64'(vld_out[k]), 0);
    wait_valid(k, n);
    check_eq("b2b_lat2", 64'(n), 64'(8 / LN[k]));
    check_eq("b2b_data", 64'(dout[k]), 64'h00000000D9CE3DCB);
    @(posedge clk); #1;
    check_eq("b2b_end", 64'(vld_out[k]), 0);
  endtask

  task automatic flush_case();
    @(negedge clk);
    din[0] = '1; vld_in[0] = 1'b1; rdy_in[0] = 1'b1;
    @(posedge clk); #1;
    vld_in[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    flush[0] = 1'b1; vld_in[0] = 1'b1; din[0] = 48'({$urandom, $urandom});
    #1;
    check_eq("flush_rdy_run", 64'(rdy_out[0]), 0);
    @(posedge clk); #1;
    check_eq("flush_rdy_idle", 64'(rdy_out[0]), 0);
    check_eq("flush_vld", 64'(vld_out[0]), 0);
    @(posedge clk); #1;
    flush[0] = 1'b0; vld_in[0] = 1'b0;
    #1;
    check_eq("post_flush_rdy", 64'(rdy_out[0]), 1);
    repeat (10) begin
      @(posedge clk); #1;
      check_eq("flush_no_vld", 64'(vld_out[0]), 0);
    end
    run_word(0, 48'h0, 0);
  endtask

  task automatic reset_case();
    @(negedge clk);
    din[0] = 48'({$urandom, $urandom}); vld_in[0] = 1'b1;
    @(posedge clk); #1;
    vld_in[0] = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_vld", 64'(vld_out[0]), 0);
    check_eq("arst_data", 64'(dout[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("arst_rdy", 64'(rdy_out[0]), 1);
    run_word(0, 48'({$urandom, $urandom}), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    logic [63:0] r;
    for (int k = 0; k < NDUT; k++) begin
      flush[k] = 1'b0; vld_in[k] = 1'b0; rdy_in[k] = 1'b1; din[k] = '0;
    end
    #12;
    for (int k = 0; k < NDUT; k++) begin
      check_eq("rst_vld", 64'(vld_out[k]), 0);
      check_eq("rst_data", 64'(dout[k]), 0);
      check_eq("rst_rdy", 64'(rdy_out[k]), 1);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < NDUT; k++) begin
      run_word(k, 48'h0, 0);
      run_word(k, 48'hFFFFFFFFFFFF, 0);
      back_to_back(k);
    end
    flush_case();
    reset_case();

    for (int k = 0; k < NDUT; k++) begin
      for (int i = 0; i < 6; i++) begin
        r = {$urandom, $urandom};
        run_word(k, r[47:0], int'($urandom_range(0, 3)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
